cmd_arbiter: RTL and testbench

Shares the single SD command-line physical controller among NUM_REQ host-side requesters (e.g. card-init engine, data-transfer engine, software register port).
- Arbitrates round-robin between requesters.
- Drives the phys controller's strobe/ack/idle handshake and forwards the granted requester's 40-bit command.
- Returns the 136-bit response to the winner.
- Enforces a response timeout; on expiry it forces the phys controller back to IDLE.

---
 rtl/cmd_arb_pkg.sv | 18 +
 rtl/cmd_arbiter_rr_picker.sv | 50 +++++
 rtl/cmd_arbiter.sv | 139 +++++++++++++
 tb/tb_cmd_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_arb_pkg.sv
// Shared types and constants for the SD command-line arbiter.
package cmd_arb_pkg;

  localparam int CMD_W              = 40;
  localparam int RESP_W             = 136;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_ACK       = 3'd4,
    ST_DONE      = 3'd5,
    ST_ABORT     = 3'd6
  } state_t;

endpackage

// File: rtl/cmd_arbiter_rr_picker.sv
// Combinational winner selection: round-robin from rr_ptr, or lowest index
// when CMD_ARB_FIXED_PRIO_EN is defined.
module rr_picker
  import cmd_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef CMD_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   rr_ptr,
`endif
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   win_idx
);

`ifdef CMD_ARB_FIXED_PRIO_EN
  always_comb begin
    winner  = '0;
    win_idx = '0;
    // Scan from the top down so the lowest active index is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end
`else
  int cand;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    cand    = 0;
    // Scan offsets farthest-first so the candidate nearest rr_ptr wins.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = int'(rr_ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand]) begin
        winner       = '0;
        winner[cand] = 1'b1;
        win_idx      = IDX_W'(cand);
      end
    end
  end
`endif

endmodule

// File: rtl/cmd_arbiter.sv
// Shares one SD command-line phys controller among NUM_REQ requesters.
// Optional build macro: CMD_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module cmd_arbiter
  import cmd_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 11
) (
  input  logic                     sd_clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [CMD_W*NUM_REQ-1:0] req_cmd,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [RESP_W-1:0]        resp_data,
  output logic                     timeout_err,
  output logic [CMD_W-1:0]         phys_cmd,
  output logic                     phys_strobe_in,
  output logic                     phys_ack_in,
  output logic                     phys_idle_in,
  input  logic                     phys_strobe_out,
  input  logic                     phys_ack_out,
  input  logic [RESP_W-1:0]        phys_response
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  state_t             next_state;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   win_idx;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_expired;

  assign cnt_expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef CMD_ARB_FIXED_PRIO_EN
  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req     (req),
    .winner  (pick_onehot),
    .win_idx (pick_idx)
  );
`else
  logic [IDX_W-1:0] rr_ptr;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (pick_onehot),
    .win_idx (pick_idx)
  );

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (state == ST_DONE) begin
      rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`endif

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: defaulting next_state first keeps this block free of inferred latches.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (|req) next_state = ST_GRANT;
      ST_GRANT:     next_state = ST_ISSUE;
      ST_ISSUE:     next_state = ST_WAIT_RESP;
      ST_WAIT_RESP: begin
        // A response on the last counted cycle still beats the timeout.
        if (phys_strobe_out)  next_state = ST_ACK;
        else if (cnt_expired) next_state = ST_ABORT;
      end
      ST_ACK: begin
        if (phys_ack_out)     next_state = ST_DONE;
        else if (cnt_expired) next_state = ST_ABORT;
      end
      ST_ABORT:     next_state = ST_DONE;
      ST_DONE:      next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    phys_strobe_in = (state == ST_ISSUE);
    phys_ack_in    = (state == ST_ACK);
    phys_idle_in   = (state == ST_ABORT);
    done           = (state == ST_DONE) ? gnt : '0;
  end

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      gnt         <= '0;
      win_idx     <= '0;
      phys_cmd    <= '0;
      resp_data   <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt     <= pick_onehot;
            win_idx <= pick_idx;
          end
        end
        ST_GRANT:     phys_cmd <= req_cmd[CMD_W*win_idx +: CMD_W];
        ST_ISSUE:     cnt <= '0;
        ST_WAIT_RESP: begin
          if (phys_strobe_out) begin
            resp_data <= phys_response;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACK:       cnt <= cnt + 1'b1;
        ST_DONE: begin
          gnt         <= '0;
          phys_cmd    <= '0;
          timeout_err <= 1'b0;
        end
        default: ;
      endcase
      // Flag is raised on the way into ABORT and survives through DONE.
      if (next_state == ST_ABORT) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed self-checking bench for cmd_arbiter (3 requesters, 16-cycle timeout).
module tb_cmd_arbiter;

  localparam int T = 16;

  logic         sd_clock = 1'b0;
  logic         reset;
  logic [2:0]   req;
  logic [119:0] req_cmd;
  logic [2:0]   gnt;
  logic [2:0]   done;
  logic [135:0] resp_data;
  logic         timeout_err;
  logic [39:0]  phys_cmd;
  logic         phys_strobe_in;
  logic         phys_ack_in;
  logic         phys_idle_in;
  logic         phys_strobe_out;
  logic         phys_ack_out;
  logic [135:0] phys_response;

  int checks = 0;
  int errors = 0;
  logic [39:0] cmds [3];

  localparam logic [135:0] R1 = 136'hA1_1234_5678_9ABC_DEF0_1111_2222_3333_4444;
  localparam logic [135:0] R2 = 136'hB2_0F0F_0F0F_0F0F_0F0F_F0F0_F0F0_F0F0_F0F0;
  localparam logic [135:0] R3 = 136'hC3_DEAD_BEEF_0000_0001_8000_0000_CAFE_F00D;
  localparam logic [135:0] R4 = 136'hD4_5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
  localparam logic [135:0] R5 = 136'hE5_0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
  localparam logic [135:0] R6 = 136'hF6_FFFF_0000_FFFF_0000_1234_4321_ABCD_DCBA;

  cmd_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(T), .CNT_W(11)) dut (
    .sd_clock        (sd_clock),
    .reset           (reset),
    .req             (req),
    .req_cmd         (req_cmd),
    .gnt             (gnt),
    .done            (done),
    .resp_data       (resp_data),
    .timeout_err     (timeout_err),
    .phys_cmd        (phys_cmd),
    .phys_strobe_in  (phys_strobe_in),
    .phys_ack_in     (phys_ack_in),
    .phys_idle_in    (phys_idle_in),
    .phys_strobe_out (phys_strobe_out),
    .phys_ack_out    (phys_ack_out),
    .phys_response   (phys_response)
  );

  always #5 sd_clock = ~sd_clock;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sd_clock);
    #1;
  endtask

  // One transaction with a phys controller answering at the first possible cycles.
  task automatic quick_txn(input int idx, input logic [135:0] resp,
                           input bit drop_after_grant, input bit release_at_done,
                           input string tag);
    logic [2:0] g;
    g = 3'b001 << idx;
    tick();
    check({tag, " gnt"}, gnt, g);
    if (drop_after_grant) req = '0;
    tick();
    check({tag, " strobe"}, phys_strobe_in, 1'b1);
    check({tag, " cmd"}, phys_cmd, cmds[idx]);
    tick();
    check({tag, " strobe_one_cycle"}, phys_strobe_in, 1'b0);
    phys_strobe_out = 1'b1;
    phys_response   = resp;
    tick();
    phys_strobe_out = 1'b0;
    check({tag, " ack_in"}, phys_ack_in, 1'b1);
    check({tag, " resp"}, resp_data, resp);
    phys_ack_out = 1'b1;
    tick();
    phys_ack_out = 1'b0;
    check({tag, " done"}, done, g);
    check({tag, " terr"}, timeout_err, 1'b0);
    if (release_at_done) req = '0;
    tick();
    check({tag, " done_cleared"}, done, 3'b000);
    check({tag, " gnt_cleared"}, gnt, 3'b000);
  endtask

  initial begin
    cmds[0] = 40'h01_1111_1111;
    cmds[1] = 40'h40_0000_0000;
    cmds[2] = 40'h7F_2222_2222;
    req_cmd         = {cmds[2], cmds[1], cmds[0]};
    req             = '0;
    phys_strobe_out = 1'b0;
    phys_ack_out    = 1'b0;
    phys_response   = '0;
    reset           = 1'b1;

    #12;
    check("rst gnt", gnt, 3'b000);
    check("rst phys_cmd", phys_cmd, 40'h0);
    check("rst resp", resp_data, 136'h0);
    check("rst done", done, 3'b000);
    check("rst terr", timeout_err, 1'b0);
    check("rst strobe", phys_strobe_in, 1'b0);
    check("rst idle", phys_idle_in, 1'b0);
    tick();
    reset = 1'b0;

    // Fairness with all three requesting.
    req = 3'b111;
`ifdef CMD_ARB_FIXED_PRIO_EN
    quick_txn(0, R1, 1'b0, 1'b0, "fair0");
    quick_txn(0, R2, 1'b0, 1'b0, "fair1");
    quick_txn(0, R3, 1'b0, 1'b0, "fair2");
    quick_txn(0, R4, 1'b0, 1'b1, "fair3");
`else
    quick_txn(0, R1, 1'b0, 1'b0, "fair0");
    quick_txn(1, R2, 1'b0, 1'b0, "fair1");
    quick_txn(2, R3, 1'b0, 1'b0, "fair2");
    quick_txn(0, R4, 1'b0, 1'b1, "fair3");
`endif

    // Single request, response 3 cycles after strobe, ack echoed next cycle.
    req = 3'b010;
    tick();
    check("single gnt", gnt, 3'b010);
    tick();
    check("single strobe", phys_strobe_in, 1'b1);
    check("single cmd", phys_cmd, 40'h40_0000_0000);
    tick();
    check("single strobe_one_cycle", phys_strobe_in, 1'b0);
    tick();
    tick();
    phys_strobe_out = 1'b1;
    phys_response   = R1;
    tick();
    phys_strobe_out = 1'b0;
    check("single ack_in", phys_ack_in, 1'b1);
    check("single resp", resp_data, R1);
    phys_ack_out = 1'b1;
    tick();
    phys_ack_out = 1'b0;
    check("single done", done, 3'b010);
    check("single terr", timeout_err, 1'b0);
    check("single ack_dropped", phys_ack_in, 1'b0);
    req = '0;
    tick();
    check("single done_cleared", done, 3'b000);
    check("single cmd_cleared", phys_cmd, 40'h0);

    // Response timeout: 16 waiting cycles, then ABORT.
    req = 3'b100;
    tick();
    check("tmo gnt", gnt, 3'b100);
    tick();
    repeat (T) tick();
    check("tmo idle_before", phys_idle_in, 1'b0);
    check("tmo terr_before", timeout_err, 1'b0);
    tick();
    check("tmo idle_pulse", phys_idle_in, 1'b1);
    check("tmo terr_abort", timeout_err, 1'b1);
    check("tmo no_early_done", done, 3'b000);
    tick();
    check("tmo done", done, 3'b100);
    check("tmo terr_done", timeout_err, 1'b1);
    check("tmo idle_one_cycle", phys_idle_in, 1'b0);
    check("tmo resp_kept", resp_data, R1);
    req = '0;
    tick();
    check("tmo terr_cleared", timeout_err, 1'b0);

    req = 3'b001;
    quick_txn(0, R2, 1'b0, 1'b1, "after_tmo");

    // Response on the last counted cycle wins over expiry.
    req = 3'b010;
    tick();
    tick();
    repeat (T) tick();
    phys_strobe_out = 1'b1;
    phys_response   = R3;
    tick();
    phys_strobe_out = 1'b0;
    check("edge no_idle", phys_idle_in, 1'b0);
    check("edge ack_in", phys_ack_in, 1'b1);
    check("edge resp", resp_data, R3);
    phys_ack_out = 1'b1;
    tick();
    phys_ack_out = 1'b0;
    check("edge done", done, 3'b010);
    check("edge terr", timeout_err, 1'b0);
    req = '0;
    tick();

    // Asynchronous reset in WAIT_RESP; rr_ptr was 2 before the reset.
    req = 3'b110;
    tick();
`ifdef CMD_ARB_FIXED_PRIO_EN
    check("rst_mid gnt", gnt, 3'b010);
`else
    check("rst_mid gnt", gnt, 3'b100);
`endif
    tick();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("rst_mid gnt_zero", gnt, 3'b000);
    check("rst_mid cmd_zero", phys_cmd, 40'h0);
    check("rst_mid strobe_zero", phys_strobe_in, 1'b0);
    check("rst_mid no_done", done, 3'b000);
    check("rst_mid no_idle", phys_idle_in, 1'b0);
    #2 reset = 1'b0;
    quick_txn(1, R4, 1'b0, 1'b1, "post_rst");

    // ACK timeout keeps the captured response.
    req = 3'b100;
    tick();
    tick();
    tick();
    phys_strobe_out = 1'b1;
    phys_response   = R5;
    tick();
    phys_strobe_out = 1'b0;
    check("ack_tmo ack_in", phys_ack_in, 1'b1);
    repeat (T - 1) tick();
    check("ack_tmo ack_last", phys_ack_in, 1'b1);
    check("ack_tmo idle_before", phys_idle_in, 1'b0);
    tick();
    check("ack_tmo idle_pulse", phys_idle_in, 1'b1);
    check("ack_tmo ack_dropped", phys_ack_in, 1'b0);
    check("ack_tmo terr", timeout_err, 1'b1);
    check("ack_tmo resp_kept", resp_data, R5);
    tick();
    check("ack_tmo done", done, 3'b100);
    check("ack_tmo terr_done", timeout_err, 1'b1);
    req = '0;
    tick();
    check("ack_tmo terr_cleared", timeout_err, 1'b0);

    // Requester withdraws right after being granted.
    req = 3'b001;
    quick_txn(0, R6, 1'b1, 1'b0, "withdraw");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
